// File: rtl/ir_cmd_ctrl_if.sv
// Command hand-off bus between the IR command controller and the main alarm FSM.
interface ir_cmd_ctrl_if;
    logic [1:0] select_main_state;
    logic       sel_valid;
    logic       sel_ack;
    logic [7:0] key_code;

    modport master (
        output select_main_state,
        output sel_valid,
        output key_code,
        input  sel_ack
    );

    modport slave (
        input  select_main_state,
        input  sel_valid,
        input  key_code,
        output sel_ack
    );
endinterface

// File: rtl/ir_cmd_ctrl.sv
// IR remote command controller: sequences the NEC decoder, validates frames, hands keys to the alarm FSM.
// Optional repeat lockout is enabled by defining IR_REPEAT_LOCK_EN.
module ir_cmd_ctrl #(
    parameter logic [15:0] CUSTOM_CODE = 16'h6B86,
    parameter bit          CHECK_ADDR  = 1'b1,
    parameter int unsigned IR_RST_CYC  = 16,
    parameter int unsigned STUCK_CYC   = 5_000_000,
    parameter int unsigned LOCKOUT_CYC = 15_000_000
) (
    input  logic          CLOCK2_50,
    input  logic          rstir,
    input  logic          enableIR,
    input  logic          ir_data_ready,
    input  logic [31:0]   ir_data,
    output logic          ir_rst_n,
    output logic [7:0]    err_cnt,
    ir_cmd_ctrl_if.master sel_bus
);

    localparam int unsigned RST_W   = $clog2(IR_RST_CYC + 1);
    localparam int unsigned MAX_CYC = (STUCK_CYC > LOCKOUT_CYC) ? STUCK_CYC : LOCKOUT_CYC;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    typedef enum logic [2:0] {
        RST_RX  = 3'd0,
        IDLE    = 3'd1,
        CAPTURE = 3'd2,
        CHECK   = 3'd3,
        PRESENT = 3'd4
    } state_t;

    state_t           state_q;
    logic             s1_q, s2_q, s3_q, rise_q;
    logic [RST_W-1:0] rst_cnt_q;
    logic [CNT_W-1:0] stuck_q;
    logic [31:0]      frame_q;
    logic             ir_rst_n_q;
    logic [1:0]       sel_q;
    logic             valid_q;
    logic [7:0]       key_q;
    logic [7:0]       err_q;
`ifdef IR_REPEAT_LOCK_EN
    logic [CNT_W-1:0] lock_q;
`endif

    logic       frame_bad;
    logic       map_hit;
    logic [1:0] map_sel;
    logic       repeat_block;

    // Frame integrity and key-to-state mapping of the captured frame.
    assign frame_bad = (frame_q[31:24] != ~frame_q[23:16]) |
                       (CHECK_ADDR && (frame_q[15:0] != CUSTOM_CODE));

    always_comb begin
        map_hit = 1'b1;
        map_sel = 2'b00;
        case (frame_q[23:16])
            8'h0F:   map_sel = 2'b01;
            8'h13:   map_sel = 2'b10;
            8'h10:   map_sel = 2'b11;
            8'h12:   map_sel = 2'b00;
            default: map_hit = 1'b0;
        endcase
    end

`ifdef IR_REPEAT_LOCK_EN
    assign repeat_block = (frame_q[23:16] == key_q) && (lock_q != '0);
`else
    assign repeat_block = 1'b0;
`endif

    always_ff @(posedge CLOCK2_50) begin
        if (rstir) begin
            state_q    <= RST_RX;
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            s3_q       <= 1'b0;
            rise_q     <= 1'b0;
            rst_cnt_q  <= RST_W'(IR_RST_CYC);
            stuck_q    <= '0;
            frame_q    <= '0;
            ir_rst_n_q <= 1'b0;
            sel_q      <= 2'b00;
            valid_q    <= 1'b0;
            key_q      <= 8'h00;
            err_q      <= 8'h00;
`ifdef IR_REPEAT_LOCK_EN
            lock_q     <= '0;
`endif
        end else begin
            // Strobe is only ever sampled; a registered rise pulse feeds IDLE.
            s1_q    <= ir_data_ready;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
            rise_q  <= s2_q & ~s3_q;
            stuck_q <= '0;
`ifdef IR_REPEAT_LOCK_EN
            if (lock_q != '0) lock_q <= lock_q - CNT_W'(1);
`endif
            case (state_q)
                RST_RX: begin
                    if (rst_cnt_q <= RST_W'(1)) begin
                        state_q    <= IDLE;
                        ir_rst_n_q <= 1'b1;
                    end else begin
                        rst_cnt_q <= rst_cnt_q - RST_W'(1);
                    end
                end
                IDLE: begin
                    if (rise_q && enableIR) begin
                        state_q <= CAPTURE;
                    end else if (s2_q) begin
                        // A strobe that never falls means the decoder is hung.
                        if (stuck_q == CNT_W'(STUCK_CYC - 1)) begin
                            state_q    <= RST_RX;
                            rst_cnt_q  <= RST_W'(IR_RST_CYC);
                            ir_rst_n_q <= 1'b0;
                        end else begin
                            stuck_q <= stuck_q + CNT_W'(1);
                        end
                    end
                end
                CAPTURE: begin
                    if (!enableIR) begin
                        state_q <= IDLE;
                    end else begin
                        frame_q <= ir_data;
                        state_q <= CHECK;
                    end
                end
                CHECK: begin
                    if (!enableIR) begin
                        state_q <= IDLE;
                    end else if (frame_bad) begin
                        if (err_q != 8'hFF) err_q <= err_q + 8'd1;
                        state_q    <= RST_RX;
                        rst_cnt_q  <= RST_W'(IR_RST_CYC);
                        ir_rst_n_q <= 1'b0;
                    end else if (!map_hit || repeat_block) begin
                        state_q <= IDLE;
                    end else begin
                        sel_q   <= map_sel;
                        key_q   <= frame_q[23:16];
                        valid_q <= 1'b1;
                        state_q <= PRESENT;
`ifdef IR_REPEAT_LOCK_EN
                        lock_q  <= CNT_W'(LOCKOUT_CYC);
`endif
                    end
                end
                PRESENT: begin
                    if (!enableIR || sel_bus.sel_ack) begin
                        valid_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q    <= RST_RX;
                    rst_cnt_q  <= RST_W'(IR_RST_CYC);
                    ir_rst_n_q <= 1'b0;
                    valid_q    <= 1'b0;
                end
            endcase
        end
    end

    assign ir_rst_n                  = ir_rst_n_q;
    assign err_cnt                   = err_q;
    assign sel_bus.select_main_state = sel_q;
    assign sel_bus.sel_valid         = valid_q;
    assign sel_bus.key_code          = key_q;

endmodule
